// File: rtl/memory_embedded_flash_programmer.sv
// Word-program / page-erase sequencer for the on-chip flash (UFM-style Avalon-MM CSR + data ports).
// Handles unprotect, status polling, success check, re-protect, and an overall poll/write timeout.
module memory_embedded_flash_programmer #(
   parameter logic [18:0] FLASH_END        = 19'h059FF,
   parameter logic [4:0]  PROTECT_LOCKED   = 5'b11111,
   parameter logic [4:0]  PROTECT_UNLOCKED = 5'b00000,
   parameter logic [23:0] TIMEOUT_CYCLES   = 24'd8_000_000
) (
   input  logic        i_clk,
   input  logic        i_reset_n,
   input  logic        i_request,
   input  logic        i_erase,
   input  logic [18:0] i_address,
   input  logic [31:0] i_data,
   output logic        o_busy,
   output logic        o_ack,
   output logic        o_error,
   output logic        o_csr_addr,
   output logic        o_csr_read,
   output logic        o_csr_write,
   output logic [31:0] o_csr_writedata,
   input  logic [31:0] i_csr_readdata,
   output logic [18:0] o_data_addr,
   output logic        o_data_write,
   output logic [31:0] o_data_writedata,
   input  logic        i_data_waitrequest
);

   typedef enum logic [3:0] {
      S_LOCK, S_IDLE, S_REJECT, S_PRE_RD, S_PRE_CHK, S_UNLOCK,
      S_WRITE, S_POLL_RD, S_POLL_CHK, S_RELOCK, S_ACK
   } state_t;

   typedef struct packed {
      logic        busy;
      logic        ack;
      logic        error;
      logic        csr_addr;
      logic        csr_read;
      logic        csr_write;
      logic [31:0] csr_writedata;
      logic [18:0] data_addr;
      logic        data_write;
      logic [31:0] data_writedata;
   } outs_t;

   function automatic logic [31:0] ctrl_word(input logic [4:0] prot, input logic erase,
                                             input logic [18:0] addr);
      ctrl_word = {4'b0000, prot, 3'b111, erase ? {1'b0, addr} : 20'hFFFFF};
   endfunction

   // Moore decode of one state; evaluated on the next state so the ports come straight from flops
   // and read as all-zero while reset is held.
   function automatic outs_t decode(input state_t st, input logic erase, input logic [18:0] addr,
                                    input logic [31:0] data, input logic result);
      outs_t o;
      o      = '0;
      o.busy = (st != S_IDLE);
      case (st)
         S_LOCK, S_RELOCK: begin
            o.csr_addr      = 1'b1;
            o.csr_write     = 1'b1;
            o.csr_writedata = ctrl_word(PROTECT_LOCKED, 1'b0, '0);
         end
         S_UNLOCK: begin
            o.csr_addr      = 1'b1;
            o.csr_write     = 1'b1;
            o.csr_writedata = ctrl_word(PROTECT_UNLOCKED, erase, addr);
         end
         S_PRE_RD, S_POLL_RD: o.csr_read = 1'b1;
         S_WRITE: begin
            o.data_write     = 1'b1;
            o.data_addr      = addr;
            o.data_writedata = {data[7:0], data[15:8], data[23:16], data[31:24]};
         end
         S_ACK: begin
            o.ack   = 1'b1;
            o.error = !result;
         end
         default: ;
      endcase
      return o;
   endfunction

   state_t      state_q, state_d;
   outs_t       outs_q;
   logic        erase_q, erase_d;
   logic [18:0] addr_q, addr_d;
   logic [31:0] data_q, data_d;
   logic        result_q, result_d;
   logic [23:0] timer_q;
   logic        timer_clear;
   logic        timed_out;
   logic        status_idle;
   logic        unused_status;

   assign status_idle   = (i_csr_readdata[1:0] == 2'b00);
   assign timed_out     = (timer_q >= TIMEOUT_CYCLES);
   assign unused_status = ^{i_csr_readdata[31:5], i_csr_readdata[2]};

   // NOTE: every variable written here gets a default first, so no path can infer a latch.
   always_comb begin
      state_d  = state_q;
      erase_d  = erase_q;
      addr_d   = addr_q;
      data_d   = data_q;
      result_d = result_q;
      case (state_q)
         S_LOCK: if (outs_q.csr_write) state_d = S_IDLE;
         S_IDLE: begin
            if (i_request) begin
               erase_d  = i_erase;
               addr_d   = i_address;
               data_d   = i_data;
               result_d = 1'b0;
               state_d  = (i_address > FLASH_END) ? S_REJECT : S_PRE_RD;
            end
         end
         S_REJECT:  state_d = S_ACK;
         S_PRE_RD:  state_d = S_PRE_CHK;
         S_PRE_CHK: begin
            if (status_idle)    state_d = S_UNLOCK;
            else if (timed_out) begin
               result_d = 1'b0;
               state_d  = S_RELOCK;
            end else            state_d = S_PRE_RD;
         end
         S_UNLOCK: state_d = erase_q ? S_POLL_RD : S_WRITE;
         S_WRITE: begin
            if (!i_data_waitrequest) state_d = S_POLL_RD;
            else if (timed_out) begin
               result_d = 1'b0;
               state_d  = S_RELOCK;
            end
         end
         S_POLL_RD:  state_d = S_POLL_CHK;
         S_POLL_CHK: begin
            if (status_idle) begin
               result_d = erase_q ? i_csr_readdata[4] : i_csr_readdata[3];
               state_d  = S_RELOCK;
            end else if (timed_out) begin
               result_d = 1'b0;
               state_d  = S_RELOCK;
            end else state_d = S_POLL_RD;
         end
         S_RELOCK: state_d = S_ACK;
         S_ACK:    state_d = S_IDLE;
         default:  state_d = S_LOCK;
      endcase
   end

   // Re-reads inside one poll loop keep counting; only a fresh entry restarts the budget.
   always_comb begin
      timer_clear = ((state_d == S_PRE_RD)  && (state_q != S_PRE_CHK)) ||
                    ((state_d == S_WRITE)   && (state_q != S_WRITE))   ||
                    ((state_d == S_POLL_RD) && (state_q != S_POLL_CHK));
   end

   // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q  <= S_LOCK;
         outs_q   <= '0;
         erase_q  <= 1'b0;
         addr_q   <= '0;
         data_q   <= '0;
         result_q <= 1'b0;
         timer_q  <= '0;
      end else begin
         state_q  <= state_d;
         outs_q   <= decode(state_d, erase_d, addr_d, data_d, result_d);
         erase_q  <= erase_d;
         addr_q   <= addr_d;
         data_q   <= data_d;
         result_q <= result_d;
         if (timer_clear)       timer_q <= '0;
         else if (timer_q != '1) timer_q <= timer_q + 24'd1;
      end
   end

   assign o_busy           = outs_q.busy;
   assign o_ack            = outs_q.ack;
   assign o_error          = outs_q.error;
   assign o_csr_addr       = outs_q.csr_addr;
   assign o_csr_read       = outs_q.csr_read;
   assign o_csr_write      = outs_q.csr_write;
   assign o_csr_writedata  = outs_q.csr_writedata;
   assign o_data_addr      = outs_q.data_addr;
   assign o_data_write     = outs_q.data_write;
   assign o_data_writedata = outs_q.data_writedata;

endmodule

// File: tb/tb_memory_embedded_flash_programmer.sv
// Self-checking bench: table of commands plus hand-written reset and timeout sequences, with a
// scoreboard of expected CSR writes and ack error flags checked by a negedge bus monitor.
module tb_memory_embedded_flash_programmer;

   localparam logic [31:0] LOCKED_WORD   = 32'h0FFF_FFFF;
   localparam logic [31:0] UNLOCK_PROG   = 32'h007F_FFFF;
   localparam logic [31:0] RD_IDLE_GARB  = 32'hDEAD_BEE3;

   logic        i_clk = 1'b0;
   logic        i_reset_n = 1'b0;
   logic        i_request = 1'b0;
   logic        i_erase = 1'b0;
   logic [18:0] i_address = '0;
   logic [31:0] i_data = '0;
   logic [31:0] i_csr_readdata = RD_IDLE_GARB;
   logic        i_data_waitrequest = 1'b0;
   logic        o_busy, o_ack, o_error, o_csr_addr, o_csr_read, o_csr_write, o_data_write;
   logic [31:0] o_csr_writedata, o_data_writedata;
   logic [18:0] o_data_addr;

   memory_embedded_flash_programmer #(.TIMEOUT_CYCLES(24'd40)) dut (
      .i_clk(i_clk), .i_reset_n(i_reset_n), .i_request(i_request), .i_erase(i_erase),
      .i_address(i_address), .i_data(i_data), .o_busy(o_busy), .o_ack(o_ack), .o_error(o_error),
      .o_csr_addr(o_csr_addr), .o_csr_read(o_csr_read), .o_csr_write(o_csr_write),
      .o_csr_writedata(o_csr_writedata), .i_csr_readdata(i_csr_readdata),
      .o_data_addr(o_data_addr), .o_data_write(o_data_write), .o_data_writedata(o_data_writedata),
      .i_data_waitrequest(i_data_waitrequest)
   );

   always #5 i_clk = ~i_clk;

   typedef enum int {M_NORMAL, M_REJECT, M_POLL_TO, M_PRE_TO} mode_t;
   typedef struct {
      mode_t       mode;
      logic        erase;
      logic [18:0] addr;
      logic [31:0] data;
      int          busy_polls;
      logic [31:0] final_status;
      logic [31:0] exp_unlock;
      logic [31:0] exp_dw;
      logic        exp_err;
   } vec_t;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] exp_csr_q[$];
   logic        exp_err_q[$];
   logic [31:0] status_q[$];
   logic [31:0] stuck_status = '0;
   int          wr_hold = 0;
   logic        rd_pending = 1'b0;
   logic [18:0] exp_dw_addr = '0;
   logic [31:0] exp_dw_data = '0;
   int          n_csr_wr = 0, n_csr_rd = 0, n_dw = 0, n_ack = 0;
   logic        prev_wr = 1'b0, prev_rd = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: actual %h, expected %h", name, act, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_ctrl"}, {25'd0, o_busy, o_ack, o_error, o_csr_addr, o_csr_read, o_csr_write,
                             o_data_write}, 32'd0);
      check({tag, "_csr_wdata"}, o_csr_writedata, 32'd0);
      check({tag, "_data_addr"}, {13'd0, o_data_addr}, 32'd0);
      check({tag, "_data_wdata"}, o_data_writedata, 32'd0);
   endtask

   // Flash model: status word valid the cycle after a read strobe; optional data-port stall.
   always @(posedge i_clk) begin
      #1;
      if (rd_pending) i_csr_readdata = (status_q.size() != 0) ? status_q.pop_front() : stuck_status;
      else            i_csr_readdata = RD_IDLE_GARB;
      rd_pending = o_csr_read;
      if (o_data_write && wr_hold > 0) begin
         i_data_waitrequest = 1'b1;
         wr_hold--;
      end else i_data_waitrequest = 1'b0;
   end

   // Bus monitor / scoreboard.
   always @(negedge i_clk) begin
      if (i_reset_n) begin
         if (o_csr_write) begin
            n_csr_wr++;
            check("csr_wr_single", {31'd0, prev_wr}, 32'd0);
            check("csr_wr_addr", {31'd0, o_csr_addr}, 32'd1);
            check("csr_wr_excl", {30'd0, o_csr_read, o_data_write}, 32'd0);
            if (exp_csr_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL csr_wr_unexpected: actual %h, expected no write", o_csr_writedata);
            end else check("csr_wr_data", o_csr_writedata, exp_csr_q.pop_front());
         end
         if (o_csr_read) begin
            n_csr_rd++;
            check("csr_rd_single", {31'd0, prev_rd}, 32'd0);
            check("csr_rd_addr", {31'd0, o_csr_addr}, 32'd0);
            check("csr_rd_excl", {31'd0, o_data_write}, 32'd0);
         end
         if (o_data_write) begin
            n_dw++;
            check("dw_addr", {13'd0, o_data_addr}, {13'd0, exp_dw_addr});
            check("dw_data", o_data_writedata, exp_dw_data);
         end
         if (o_ack) begin
            n_ack++;
            check("ack_busy", {31'd0, o_busy}, 32'd1);
            if (exp_err_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL ack_unexpected: actual ack error=%b, expected no ack", o_error);
            end else check("ack_error", {31'd0, o_error}, {31'd0, exp_err_q.pop_front()});
         end
         prev_wr = o_csr_write;
         prev_rd = o_csr_read;
      end else begin
         prev_wr = 1'b0;
         prev_rd = 1'b0;
      end
   end

   task automatic run_cmd(input vec_t v, input int hold, input bit extra_req);
      int c0_wr, c0_rd, c0_dw, c0_ack, cyc, exp_wr, exp_dw_n;
      bit got;
      status_q.delete();
      stuck_status = '0;
      case (v.mode)
         M_NORMAL: begin
            status_q.push_back(32'h0);
            repeat (v.busy_polls) status_q.push_back(32'h2);
            status_q.push_back(v.final_status);
         end
         M_POLL_TO: begin
            status_q.push_back(32'h0);
            stuck_status = 32'h1;
         end
         M_PRE_TO: stuck_status = 32'h1;
         default: ;
      endcase
      if (v.mode == M_NORMAL || v.mode == M_POLL_TO) exp_csr_q.push_back(v.exp_unlock);
      if (v.mode != M_REJECT) exp_csr_q.push_back(LOCKED_WORD);
      exp_err_q.push_back(v.exp_err);
      exp_dw_addr = v.addr;
      exp_dw_data = v.exp_dw;
      wr_hold     = hold;
      c0_wr = n_csr_wr; c0_rd = n_csr_rd; c0_dw = n_dw; c0_ack = n_ack;

      @(negedge i_clk);
      i_request = 1'b1; i_erase = v.erase; i_address = v.addr; i_data = v.data;
      cyc = 0;
      got = 1'b0;
      while (!got && cyc < 400) begin
         @(negedge i_clk);
         cyc++;
         if (cyc == 1) begin
            i_request = 1'b0;
            i_erase   = ~v.erase;
            i_address = 19'($urandom);
            i_data    = $urandom;
         end
         if (extra_req && cyc == 4) begin
            i_request = 1'b1;
            i_address = v.addr ^ 19'h1;
         end
         if (extra_req && cyc == 5) i_request = 1'b0;
         if (o_ack) got = 1'b1;
      end
      check("ack_seen", {31'd0, got}, 32'd1);
      if (v.mode == M_REJECT) check("reject_latency", 32'(cyc), 32'd2);
      repeat (4) @(negedge i_clk);

      exp_wr   = (v.mode == M_REJECT) ? 0 : (v.mode == M_PRE_TO) ? 1 : 2;
      exp_dw_n = ((v.mode == M_NORMAL || v.mode == M_POLL_TO) && !v.erase) ? 1 + hold : 0;
      check("ack_count", 32'(n_ack - c0_ack), 32'd1);
      check("csr_wr_count", 32'(n_csr_wr - c0_wr), 32'(exp_wr));
      check("dw_count", 32'(n_dw - c0_dw), 32'(exp_dw_n));
      if (v.mode == M_NORMAL) check("csr_rd_count", 32'(n_csr_rd - c0_rd), 32'(2 + v.busy_polls));
      if (v.mode == M_REJECT) check("csr_rd_count", 32'(n_csr_rd - c0_rd), 32'd0);
      check("idle_busy", {31'd0, o_busy}, 32'd0);
   endtask

   initial begin
      vec_t vecs[10];
      vec_t wv;
      int   busy_cnt, c0, cyc;

      //         mode       er   addr       data           polls final   unlock         dw            err
      vecs[0] = '{M_NORMAL,  0, 19'h00010, 32'h1122_3344, 3, 32'h08, UNLOCK_PROG,   32'h4433_2211, 1'b0};
      vecs[1] = '{M_NORMAL,  1, 19'h01234, 32'h0,         1, 32'h08, 32'h0070_1234, 32'h0,         1'b1};
      vecs[2] = '{M_REJECT,  0, 19'h05A00, 32'hDEAD_BEEF, 0, 32'h00, 32'h0,         32'h0,         1'b1};
      vecs[3] = '{M_NORMAL,  0, 19'h059FF, 32'hA5A5_0F0F, 0, 32'h08, UNLOCK_PROG,   32'h0F0F_A5A5, 1'b0};
      vecs[4] = '{M_NORMAL,  1, 19'h059FF, 32'h0,         2, 32'h10, 32'h0070_59FF, 32'h0,         1'b0};
      vecs[5] = '{M_REJECT,  0, 19'h7FFFF, 32'h0000_0001, 0, 32'h00, 32'h0,         32'h0,         1'b1};
      vecs[6] = '{M_NORMAL,  0, 19'h00400, 32'hCAFE_F00D, 1, 32'h10, UNLOCK_PROG,   32'h0DF0_FECA, 1'b1};
      vecs[7] = '{M_NORMAL,  1, 19'h00000, 32'h0,         0, 32'h18, 32'h0070_0000, 32'h0,         1'b0};
      vecs[8] = '{M_POLL_TO, 0, 19'h00030, 32'h5566_7788, 0, 32'h00, UNLOCK_PROG,   32'h8877_6655, 1'b1};
      vecs[9] = '{M_PRE_TO,  1, 19'h00040, 32'h0,         0, 32'h00, 32'h0,         32'h0,         1'b1};
      wv      = '{M_NORMAL,  0, 19'h00020, 32'h0102_0304, 1, 32'h08, UNLOCK_PROG,   32'h0403_0201, 1'b0};

      // Reset state, then the single post-reset lock write.
      #23;
      check_all_zero("reset");
      exp_csr_q.push_back(LOCKED_WORD);
      @(negedge i_clk);
      i_reset_n = 1'b1;
      busy_cnt = 0;
      repeat (6) begin
         @(negedge i_clk);
         if (o_busy) busy_cnt++;
      end
      check("post_reset_busy_cycles", 32'(busy_cnt), 32'd1);
      check("post_reset_lock_writes", 32'(n_csr_wr), 32'd1);

      for (int i = 0; i < 10; i++) run_cmd(vecs[i], 0, 1'b0);

      // Data-port stall for 5 cycles plus a request arriving while busy.
      run_cmd(wv, 5, 1'b1);

      // Reset in the middle of the program poll loop.
      status_q.delete();
      status_q.push_back(32'h0);
      stuck_status = 32'h1;
      exp_csr_q.push_back(UNLOCK_PROG);
      exp_dw_addr = 19'h00100;
      exp_dw_data = 32'h7856_3412;
      c0 = n_csr_wr;
      @(negedge i_clk);
      i_request = 1'b1; i_erase = 1'b0; i_address = 19'h00100; i_data = 32'h1234_5678;
      @(negedge i_clk);
      i_request = 1'b0;
      cyc = 0;
      while (n_csr_wr == c0 && cyc < 50) begin
         @(negedge i_clk);
         cyc++;
      end
      check("mid_unlock_seen", 32'(n_csr_wr - c0), 32'd1);
      repeat (6) @(negedge i_clk);
      check("mid_in_poll_busy", {31'd0, o_busy}, 32'd1);
      #2 i_reset_n = 1'b0;
      #1 check_all_zero("mid_reset");
      exp_csr_q.delete();
      status_q.delete();
      stuck_status = '0;
      exp_csr_q.push_back(LOCKED_WORD);
      c0 = n_csr_wr;
      @(negedge i_clk);
      i_reset_n = 1'b1;
      repeat (5) @(negedge i_clk);
      check("mid_lock_after_reset", 32'(n_csr_wr - c0), 32'd1);
      check("mid_idle_after_lock", {31'd0, o_busy}, 32'd0);

      check("csr_queue_drained", 32'(exp_csr_q.size()), 32'd0);
      check("ack_queue_drained", 32'(exp_err_q.size()), 32'd0);
      check("total_acks", 32'(n_ack), 32'd11);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
